// File: rtl/client_menu_dispatch.sv
// Second-level menu controller: title while idle, one-hot child selection on confirm,
// timed error text for bad selections. Optional ACTIVE inactivity timeout: CLIENT_MENU_TIMEOUT_EN.
module client_menu_dispatch #(
  parameter int                N_CHILD  = 4,
  parameter int                SEL_W    = 8,
  parameter int                SHOW_W   = 30,
  parameter int                IDX_W    = 4,
  parameter logic [SHOW_W-1:0] TITLE    = 30'h3FFFEE36,
  parameter logic [SHOW_W-1:0] ERR_TEXT = 30'h3FFFE30E,
  parameter int                ERR_CYC  = 16
`ifdef CLIENT_MENU_TIMEOUT_EN
  ,
  parameter int                TIMEOUT_CYC = 1000
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [2:0]                press,
  input  logic [SEL_W-1:0]          switch,
  input  logic [N_CHILD*SHOW_W-1:0] child_show_i,
  input  logic [N_CHILD-1:0]        child_done_i,
  output logic [N_CHILD-1:0]        child_en_o,
  output logic [SHOW_W-1:0]         show_o,
  output logic [IDX_W-1:0]          led_small_o,
  output logic                      parent_rst_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_ERR
  } state_t;

  localparam logic [2:0] P_RLS = 3'b001;
  localparam logic [2:0] P_CON = 3'b010;
  localparam logic [2:0] P_RIS = 3'b100;
  localparam int         CNT_W = $clog2(ERR_CYC + 1);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   sel, sel_nxt;
  logic [CNT_W-1:0]   err_cnt, err_nxt;

  logic               sw_onehot, sw_valid;
  logic [IDX_W-1:0]   sw_idx;
  logic               done_sel;
  logic               timeout_hit;

  logic [N_CHILD-1:0] child_en_d;
  logic [SHOW_W-1:0]  show_d;
  logic [IDX_W-1:0]   led_d;
  logic               prst_d;

`ifdef CLIENT_MENU_TIMEOUT_EN
  localparam logic [2:0] P_NONE = 3'b111;
  localparam int         TO_W   = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt, to_nxt;

  // Counts quiet cycles spent in ACTIVE; any press or a fresh entry restarts it.
  always_comb begin
    to_nxt = '0;
    if (en && state == S_ACTIVE && state_nxt == S_ACTIVE && press == P_NONE)
      to_nxt = to_cnt + TO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) to_cnt <= '0;
    else     to_cnt <= to_nxt;
  end

  assign timeout_hit = (state == S_ACTIVE) && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // A valid selection is exactly one switch bit set, and that bit addresses a child.
  assign sw_onehot = (switch != '0) && ((switch & (switch - SEL_W'(1))) == '0);
  assign sw_valid  = sw_onehot && (|switch[N_CHILD-1:0]);

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    sw_idx   = '0;
    done_sel = 1'b0;
    for (int k = 0; k < N_CHILD; k++) begin
      if (switch[k])           sw_idx   = IDX_W'(k);
      if (sel == IDX_W'(k))    done_sel = child_done_i[k];
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state        <= S_IDLE;
      sel          <= '0;
      err_cnt      <= '0;
      child_en_o   <= '0;
      show_o       <= '0;
      led_small_o  <= '0;
      parent_rst_o <= 1'b0;
    end else begin
      state        <= state_nxt;
      sel          <= sel_nxt;
      err_cnt      <= err_nxt;
      child_en_o   <= child_en_d;
      show_o       <= show_d;
      led_small_o  <= led_d;
      parent_rst_o <= prst_d;
    end
  end

  // Next-state logic; en low overrides everything but rst.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    err_nxt   = err_cnt;
    if (!en) begin
      state_nxt = S_IDLE;
      sel_nxt   = '0;
      err_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (press == P_CON) begin
            if (sw_valid) begin
              state_nxt = S_ACTIVE;
              sel_nxt   = sw_idx;
            end else begin
              state_nxt = S_ERR;
              err_nxt   = CNT_W'(ERR_CYC - 1);
            end
          end
        end
        S_ACTIVE: begin
          if (press == P_RIS || done_sel || timeout_hit) begin
            state_nxt = S_IDLE;
            sel_nxt   = '0;
          end
        end
        S_ERR: begin
          if (press == P_RIS || err_cnt == '0) begin
            state_nxt = S_IDLE;
            err_nxt   = '0;
          end else begin
            err_nxt = err_cnt - CNT_W'(1);
          end
        end
        default: begin
          state_nxt = S_IDLE;
          sel_nxt   = '0;
          err_nxt   = '0;
        end
      endcase
    end
  end

  // Output values derived from the next state so responses land on the sampling edge.
  always_comb begin
    child_en_d = '0;
    show_d     = '0;
    led_d      = '0;
    prst_d     = 1'b0;
    if (en) begin
      case (state_nxt)
        S_IDLE: begin
          show_d = TITLE;
          prst_d = (state == S_IDLE) && (press == P_RLS);
        end
        S_ACTIVE: begin
          for (int k = 0; k < N_CHILD; k++) begin
            if (sel_nxt == IDX_W'(k)) begin
              child_en_d[k] = 1'b1;
              show_d        = child_show_i[k*SHOW_W +: SHOW_W];
            end
          end
          led_d = sel_nxt + IDX_W'(1);
        end
        S_ERR: begin
          show_d = ERR_TEXT;
        end
        default: begin
          show_d = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_client_menu_dispatch.sv
// Self-checking bench for client_menu_dispatch: directed scenarios plus randomized
// stimulus compared against a menu-level behavioural model.
module tb_client_menu_dispatch;

  localparam int          N     = 4;
  localparam int          SW    = 8;
  localparam int          SH    = 30;
  localparam int          IW    = 4;
  localparam int          ERRC  = 16;
  localparam logic [29:0] TITLE = 30'h3FFFEE36;
  localparam logic [29:0] ERRT  = 30'h3FFFE30E;
  localparam logic [2:0]  NXT = 3'b000, RLS = 3'b001, CON = 3'b010, DEL = 3'b011;
  localparam logic [2:0]  RIS = 3'b100, NONE = 3'b111;

  logic            clk = 1'b0;
  logic            rst, en;
  logic [2:0]      press;
  logic [SW-1:0]   sw;
  logic [N*SH-1:0] cshow;
  logic [N-1:0]    cdone;
  logic [N-1:0]    child_en_o;
  logic [SH-1:0]   show_o;
  logic [IW-1:0]   led_small_o;
  logic            parent_rst_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: which child is open (-1 none) and how many error cycles have been shown (0 none).
  int            m_child;
  int            m_err_seen;
  logic [N-1:0]  e_en;
  logic [SH-1:0] e_show;
  logic [IW-1:0] e_led;
  logic          e_prst;

  client_menu_dispatch dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .press        (press),
    .switch       (sw),
    .child_show_i (cshow),
    .child_done_i (cdone),
    .child_en_o   (child_en_o),
    .show_o       (show_o),
    .led_small_o  (led_small_o),
    .parent_rst_o (parent_rst_o)
  );

  always #5 clk = ~clk;

  function automatic void model();
    e_prst = 1'b0;
    if (rst || !en) begin
      m_child    = -1;
      m_err_seen = 0;
      e_en = '0; e_show = '0; e_led = '0;
      return;
    end
    if (m_child >= 0) begin
      if (press == RIS || cdone[m_child]) m_child = -1;
    end else if (m_err_seen > 0) begin
      if (press == RIS || m_err_seen == ERRC) m_err_seen = 0;
      else m_err_seen++;
    end else if (press == CON) begin
      if ($countones(sw) == 1 && int'(sw) < (1 << N)) m_child = $clog2(int'(sw));
      else m_err_seen = 1;
    end else if (press == RLS) begin
      e_prst = 1'b1;
    end
    if (m_child >= 0) begin
      e_en   = N'(1) << m_child;
      e_show = cshow[m_child*SH +: SH];
      e_led  = IW'(m_child + 1);
    end else begin
      e_en   = '0;
      e_led  = '0;
      e_show = (m_err_seen > 0) ? ERRT : TITLE;
    end
  endfunction

  // One clock: inputs are already stable; model follows the edge, outputs sampled 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; press = NONE;
    cycle();
    n_cmp++;
    if ({child_en_o, show_o, led_small_o, parent_rst_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got=%h required=0", {child_en_o, show_o, led_small_o, parent_rst_o});
    end
    rst = 1'b0; en = 1'b1;
    cycle();
    n_cmp++;
    if (show_o !== TITLE || child_en_o !== 4'b0000 || led_small_o !== 4'd0) begin
      n_bad++;
      $display("FAIL idle_title got show=%h en=%b led=%0d required show=%h en=0000 led=0",
               show_o, child_en_o, led_small_o, TITLE);
    end
  endtask

  task automatic test_select();
    cshow[2*SH +: SH] = 30'h12345;
    sw = 8'b0000_0100; press = CON;
    cycle();
    press = NONE;
    n_cmp++;
    if (child_en_o !== 4'b0100 || led_small_o !== 4'd3) begin
      n_bad++;
      $display("FAIL select_child2 got en=%b led=%0d required en=0100 led=3", child_en_o, led_small_o);
    end
    sw = 8'b0000_0001;
    cycle();
    n_cmp++;
    if (show_o !== 30'h12345 || child_en_o !== 4'b0100) begin
      n_bad++;
      $display("FAIL child_text got show=%h en=%b required show=12345 en=0100", show_o, child_en_o);
    end
    press = DEL;
    cycle();
    press = NXT;
    cycle();
    press = CON;
    cycle();
    press = NONE;
    n_cmp++;
    if (child_en_o !== 4'b0100 || led_small_o !== 4'd3) begin
      n_bad++;
      $display("FAIL presses_forwarded got en=%b led=%0d required en=0100 led=3", child_en_o, led_small_o);
    end
  endtask

  task automatic test_done_ris();
    cdone = 4'b0010;
    cycle();
    cdone = '0;
    n_cmp++;
    if (child_en_o !== 4'b0100 || led_small_o !== 4'd3) begin
      n_bad++;
      $display("FAIL other_done_ignored got en=%b led=%0d required en=0100 led=3", child_en_o, led_small_o);
    end
    press = RIS; cdone = 4'b0100;
    cycle();
    press = NONE; cdone = '0;
    n_cmp++;
    if (child_en_o !== 4'b0000 || show_o !== TITLE || led_small_o !== 4'd0 || parent_rst_o !== 1'b0) begin
      n_bad++;
      $display("FAIL ris_and_done got en=%b show=%h led=%0d prst=%b required en=0000 show=%h led=0 prst=0",
               child_en_o, show_o, led_small_o, parent_rst_o, TITLE);
    end
  endtask

  task automatic test_err();
    logic [SW-1:0] bad_sw [2];
    int            shown;
    bad_sw[0] = 8'b0000_0011;
    bad_sw[1] = 8'b0001_0000;
    for (int t = 0; t < 2; t++) begin
      sw = bad_sw[t]; press = CON;
      cycle();
      press = NONE;
      shown = 0;
      for (int c = 0; c < 40 && show_o === ERRT; c++) begin
        shown++;
        if (c == 3) press = CON;
        cycle();
        press = NONE;
      end
      n_cmp++;
      if (shown !== ERRC || show_o !== TITLE || child_en_o !== 4'b0000) begin
        n_bad++;
        $display("FAIL err_hold_%0d got cycles=%0d show=%h en=%b required cycles=%0d show=%h en=0000",
                 t, shown, show_o, child_en_o, ERRC, TITLE);
      end
    end
    sw = 8'b0000_0000; press = CON;
    cycle();
    press = RIS;
    cycle();
    press = NONE;
    n_cmp++;
    if (show_o !== TITLE) begin
      n_bad++;
      $display("FAIL err_ris_exit got show=%h required %h", show_o, TITLE);
    end
  endtask

  task automatic test_rls();
    press = RLS;
    cycle();
    press = NONE;
    n_cmp++;
    if (parent_rst_o !== 1'b1 || show_o !== TITLE) begin
      n_bad++;
      $display("FAIL rls_pulse got prst=%b show=%h required prst=1 show=%h", parent_rst_o, show_o, TITLE);
    end
    cycle();
    n_cmp++;
    if (parent_rst_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rls_one_cycle got prst=%b required 0", parent_rst_o);
    end
  endtask

  task automatic test_en_drop();
    sw = 8'b0000_0010; press = CON;
    cycle();
    press = NONE;
    for (int c = 0; c < 40; c++) cycle();
`ifndef CLIENT_MENU_TIMEOUT_EN
    n_cmp++;
    if (child_en_o !== 4'b0010 || led_small_o !== 4'd2) begin
      n_bad++;
      $display("FAIL active_held got en=%b led=%0d required en=0010 led=2", child_en_o, led_small_o);
    end
`endif
    en = 1'b0; press = RLS;
    cycle();
    press = NONE;
    n_cmp++;
    if ({child_en_o, show_o, led_small_o, parent_rst_o} !== '0) begin
      n_bad++;
      $display("FAIL en_low_quiet got=%h required=0", {child_en_o, show_o, led_small_o, parent_rst_o});
    end
    en = 1'b1;
    cycle();
    n_cmp++;
    if (show_o !== TITLE || child_en_o !== 4'b0000) begin
      n_bad++;
      $display("FAIL en_return_title got show=%h en=%b required show=%h en=0000", show_o, child_en_o, TITLE);
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 59) != 0);
      r = $urandom_range(0, 15);
      case (r)
        0, 1:    press = CON;
        2:       press = RIS;
        3:       press = RLS;
        4:       press = NXT;
        5:       press = DEL;
        6:       press = 3'b101;
        default: press = NONE;
      endcase
      if ($urandom_range(0, 1) == 1) sw = SW'(1) << $urandom_range(0, SW - 1);
      else                           sw = SW'($urandom);
      for (int k = 0; k < N; k++) begin
        cshow[k*SH +: SH] = SH'($urandom);
        cdone[k]          = ($urandom_range(0, 11) == 0);
      end
      cycle();
      n_cmp++;
      if ({child_en_o, show_o, led_small_o, parent_rst_o} !== {e_en, e_show, e_led, e_prst}) begin
        n_bad++;
        $display("FAIL random_%0d got en=%b show=%h led=%0d prst=%b required en=%b show=%h led=%0d prst=%b",
                 i, child_en_o, show_o, led_small_o, parent_rst_o, e_en, e_show, e_led, e_prst);
      end
    end
    rst = 1'b0; en = 1'b1; press = NONE; cdone = '0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; press = NONE; sw = '0; cshow = '0; cdone = '0;
    m_child = -1; m_err_seen = 0;
    e_en = '0; e_show = '0; e_led = '0; e_prst = 1'b0;
    #1;
    test_reset();
    test_select();
    test_done_ris();
    test_err();
    test_rls();
    test_en_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/client_menu_dispatch.md
Name: client_menu_dispatch

Overview:
- Generic second-level menu controller for the client UI tree.
- Shows a title while idle and selects one of N_CHILD sub-menus from a one-hot switch word on a confirm press.
- While a sub-menu runs: enables it, forwards its 7-seg text, and returns to idle on back-press, on the child's done pulse, or on parent disable.
- Successor of the fixed 3-child VIP menu. Adds a parametrised child count, a timed "Err" display for invalid selections, and a one-cycle parent-release pulse.

Parameters:
- N_CHILD, 4, number of sub-menus; legal range 2..8.
- SEL_W, 8, switch width; must be >= N_CHILD.
- SHOW_W, 30, display word width (6 glyphs x 5 bits).
- IDX_W, 4, width of led_small; must satisfy 2^IDX_W > N_CHILD.
- TITLE, 30'h3FFFEE36, idle text {blank,blank,blank,v,i,p}.
- ERR_TEXT, 30'h3FFFE30E, error text {blank,blank,blank,r,r,e}.
- ERR_CYC, 16, number of cycles the error text is held.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  parent enable; low forces IDLE and quiet outputs.
- press  in  3  button code, valid for one cycle per event: 000 nxt, 001 rls, 010 con, 011 del, 100 ris, 111 none.
- switch  in  SEL_W  selection switches.
- child_show_i  in  N_CHILD*SHOW_W  child texts; child k occupies bits [k*SHOW_W +: SHOW_W].
- child_done_i  in  N_CHILD  child k requests return to idle (level or pulse).
- child_en_o  out  N_CHILD  one-hot enable of the active child.
- show_o  out  SHOW_W  display text.
- led_small_o  out  IDX_W  0 in IDLE/ERR, k+1 while child k is active.
- parent_rst_o  out  1  one-cycle release request to the parent.

Behaviour:
- All outputs are registered and computed from the next state. Every response lands on the same edge that samples the event (1-clock latency).
- Reset (rst=1 at posedge): state=IDLE, sel=0, err_cnt=0, child_en_o=0, show_o=0, led_small_o=0, parent_rst_o=0.
- en=0: same values as reset, except show_o holds 0. en has priority over every other input except rst.
- IDLE:
  - show_o=TITLE, child_en_o=0.
  - con with switch one-hot at bit k, k<N_CHILD → ACTIVE(k).
  - con with switch zero, multi-hot, or bit >= N_CHILD → ERR, err_cnt=ERR_CYC-1.
  - rls → parent_rst_o=1 for exactly one cycle; state stays IDLE.
  - Any other press → no effect.
- ACTIVE(k):
  - child_en_o = 1<<k; show_o = child slice k, registered (one cycle behind the child); led_small_o = k+1.
  - ris or child_done_i[k] → IDLE. Both in the same cycle → IDLE once, no side effect.
  - Done bits of non-selected children are ignored.
  - switch changes are ignored.
  - All other presses are passed to the child (the child sees press directly) and leave the state unchanged.
- ERR:
  - show_o=ERR_TEXT, child_en_o=0; err_cnt decrements each cycle; at 0 → IDLE.
  - ris → IDLE immediately.
  - con in ERR is ignored, with no re-selection until IDLE.
- parent_rst_o is 0 in every cycle except the one following an rls in IDLE.
- child_en_o is never multi-hot. On ACTIVE→IDLE, child_en_o clears on the same edge the state changes.

Optional Feature:
- Macro CLIENT_MENU_TIMEOUT_EN.
- Defined: adds parameter TIMEOUT_CYC (default 1000) and a counter that is reset on any press != none or on entering ACTIVE. Reaching TIMEOUT_CYC-1 in ACTIVE forces IDLE as if ris had been pressed.
- Undefined: no counter; ACTIVE is held indefinitely.

Test Plan:
- Reset, then en=1 with press=none → show_o=30'h3FFFEE36, child_en_o=0, led_small_o=0.
- switch=8'b0000_0100, press con → next cycle child_en_o=4'b0100, led_small_o=3. With child_show_i slice 2 = 30'h12345, show_o=30'h12345 one cycle later.
- In ACTIVE(2): pulse child_done_i[1] → no change. Then pulse ris and child_done_i[2] together → IDLE, child_en_o=0, TITLE shown.
- switch=8'b0000_0011, press con → show_o=30'h3FFFE30E for 16 cycles, then TITLE. Repeat with switch=8'b0001_0000 (bit4 >= N_CHILD) → same result.
- In IDLE, press rls → parent_rst_o high exactly one cycle. Drop en mid-ACTIVE → all outputs 0 next cycle; raising en again shows TITLE.
- With CLIENT_MENU_TIMEOUT_EN and TIMEOUT_CYC=8: enter ACTIVE(0) with no presses → IDLE after 8 cycles. Pressing nxt at cycle 5 delays the return to cycle 13.
